seq_divider_16bit: RTL
======================

SEQ_DIVIDER_16BIT -- requirements
Module: seq_divider_16bit

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed: 32-bit dividend, 16-bit divisor, quotient and remainder.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; SHALL be sampled only when busy=0.
REQ-005 dividend  input  32  unsigned dividend; SHALL be sampled with start.
REQ-006 divisor  input  16  unsigned divisor; SHALL be sampled with start.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse marking valid results.
REQ-009 quotient  output  16  unsigned quotient.
REQ-010 remainder  output  16  unsigned remainder.
REQ-011 div_by_zero  output  1  divisor was zero for the last operation.
REQ-012 overflow  output  1  quotient of the last operation does not fit in 16 bits.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and FIN.
- IDLE to CALC: start=1 and the operands are legal.
- IDLE to FIN: start=1 and the operands are illegal (REQ-017, REQ-018).
- CALC to FIN: after the 16th iteration.
- FIN to IDLE: unconditionally, after one cycle.
REQ-014 Accept: on the accepting edge the operands SHALL be latched internally.
- The input ports SHALL be don't-care afterwards.
- busy SHALL be 1 from the accepting edge until the edge that leaves FIN.
REQ-015 Algorithm: unsigned restoring division, one quotient bit per CALC cycle, MSB first.
- Partial remainder register: 17 bits, initialised to {1'b0, dividend[31:16]}.
- Each step: shift {R[15:0], next dividend bit}; trial subtract {1'b0, divisor}.
- No borrow: keep the difference and set the quotient bit to 1. Borrow: keep the shifted value and set the quotient bit to 0.
REQ-016 Latency for legal operands:
- Accept at edge N; iterations occur at edges N+1 through N+16.
- done=1, and quotient/remainder valid, in the cycle following edge N+17.
REQ-017 If divisor=0:
- CALC SHALL be skipped and FIN entered at edge N+1.
- Results: div_by_zero=1, overflow=0, quotient=16'hFFFF, remainder=dividend[15:0].
REQ-018 If divisor≠0 and dividend[31:16] >= divisor:
- CALC SHALL be skipped and FIN entered at edge N+1.
- Results: overflow=1, div_by_zero=0, quotient=16'hFFFF, remainder=16'h0000.
REQ-019 For legal operands, div_by_zero=0, overflow=0, and dividend = quotient*divisor + remainder with remainder < divisor.
REQ-020 done SHALL be high for exactly one cycle, the FIN cycle, per accepted operation.
REQ-021 quotient, remainder, div_by_zero and overflow SHALL update only on entry to FIN.
- They SHALL hold until the next operation's FIN.
- Intermediate iteration values SHALL NOT appear on these outputs.
REQ-022 start while busy=1, including during FIN, SHALL be ignored with no effect on the operation in progress.
- start may be accepted in the first IDLE cycle after FIN, giving a back-to-back period of 18 cycles.
REQ-023 Arithmetic SHALL be unsigned throughout, with no sign extension of any operand.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, force:
- the FSM to IDLE;
- busy=0, done=0, div_by_zero=0, overflow=0;
- quotient=16'h0000, remainder=16'h0000;
- the iteration counter and internal registers to 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation: no done pulse, and outputs as in REQ-024.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 dividend=32'd100000, divisor=16'd300 -> done 17 cycles after accept; quotient=333, remainder=100, both flags 0.
REQ-028 dividend=32'hFFFE0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0, overflow=0.
REQ-029 divisor=0, dividend=32'h12345678 -> done at N+1; div_by_zero=1, quotient=16'hFFFF, remainder=16'h5678.
REQ-030 dividend=32'h00050000, divisor=16'd5 -> done at N+1; overflow=1, quotient=16'hFFFF, remainder=0.
REQ-031 Accept 1000/7, then pulse start with 9/3 at cycle N+5 -> ignored; result 142 r 6; a new start in the next IDLE cycle yields 3 r 0.
REQ-032 Accept 1000/7, drop rst_n at N+8 -> busy=0 and outputs 0 at once with no clk edge; no done; the next operation completes correctly.

Source files
------------

// File: rtl/seq_divider_16bit_if.sv
// Request/result bundle for the 16-bit sequential divider.
// The master drives operands and start; the slave (the divider) returns status and results.
interface seq_divider_16bit_if;
    logic        start;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider_16bit.sv
// Unsigned 32/16 restoring divider, one quotient bit per cycle, MSB first.
// Illegal operands (zero divisor or quotient wider than 16 bits) bypass the iterations.
module seq_divider_16bit (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_divider_16bit_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic [4:0]  cnt_q;
    logic [15:0] rem_q;
    logic [15:0] sh_q;
    logic [15:0] dvs_q;
    logic        dz_pend_q;
    logic        ov_pend_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] quo_q;
    logic [15:0] rmd_q;
    logic        dbz_q;
    logic        ovf_q;

    logic        div_zero_s;
    logic        hi_ge_s;
    logic        illegal_s;
    logic        accept_s;
    logic        step_s;
    logic        fin_entry_s;
    logic        leave_fin_s;
    logic [16:0] shifted_s;
    logic [16:0] diff_s;
    logic        borrow_s;

    assign div_zero_s = (bus.divisor == 16'd0);
    assign hi_ge_s    = (bus.dividend[31:16] >= bus.divisor);
    assign illegal_s  = div_zero_s | hi_ge_s;

    // Trial step: bring in the next dividend bit, subtract the zero-extended divisor.
    assign shifted_s = {rem_q, sh_q[15]};
    assign diff_s    = shifted_s - {1'b0, dvs_q};
    assign borrow_s  = (shifted_s < {1'b0, dvs_q});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accepted illegal request spends its first cycle in IDLE with busy set
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    state_d = FIN;
                end else if (bus.start && !illegal_s) begin
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q == 5'd16) begin
                    state_d = FIN;
                end else begin
                    state_d = CALC;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control decode from the current state
    always_comb begin
        accept_s    = 1'b0;
        step_s      = 1'b0;
        fin_entry_s = 1'b0;
        leave_fin_s = 1'b0;
        case (state_q)
            IDLE: begin
                accept_s    = bus.start & ~busy_q;
                fin_entry_s = busy_q;
            end
            CALC: begin
                step_s      = (cnt_q != 5'd16);
                fin_entry_s = (cnt_q == 5'd16);
            end
            FIN: begin
                leave_fin_s = 1'b1;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Datapath, status and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 5'd0;
            rem_q     <= 16'd0;
            sh_q      <= 16'd0;
            dvs_q     <= 16'd0;
            dz_pend_q <= 1'b0;
            ov_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= 16'd0;
            rmd_q     <= 16'd0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= fin_entry_s;
            if (accept_s) begin
                busy_q    <= 1'b1;
                cnt_q     <= 5'd0;
                rem_q     <= bus.dividend[31:16];
                sh_q      <= bus.dividend[15:0];
                dvs_q     <= bus.divisor;
                dz_pend_q <= div_zero_s;
                ov_pend_q <= ~div_zero_s & hi_ge_s;
            end else if (step_s) begin
                cnt_q <= cnt_q + 5'd1;
                rem_q <= borrow_s ? shifted_s[15:0] : diff_s[15:0];
                // sh_q drains dividend bits from the top and fills with quotient bits
                sh_q  <= {sh_q[14:0], ~borrow_s};
            end else if (leave_fin_s) begin
                busy_q <= 1'b0;
            end
            if (fin_entry_s) begin
                dbz_q <= dz_pend_q;
                ovf_q <= ov_pend_q;
                if (dz_pend_q) begin
                    quo_q <= 16'hFFFF;
                    rmd_q <= sh_q;
                end else if (ov_pend_q) begin
                    quo_q <= 16'hFFFF;
                    rmd_q <= 16'h0000;
                end else begin
                    quo_q <= sh_q;
                    rmd_q <= rem_q;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;

endmodule
